// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin arbiter that sequences
// four requesters onto one 4:1 single-bit mux.
package mux_rr_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } arb_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// Existing 4:1 single-bit mux shared by the requesters; index = {c1,c0}.
module mux (
  input  logic x0,
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic c0,
  input  logic c1,
  output logic m
);

  assign m = c1 ? (c0 ? x3 : x2) : (c0 ? x1 : x0);

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter: grants one requester at a time for at most MAX_HOLD
// cycles, steers the shared mux from the grant and registers its output.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             x0,
  input  logic             x1,
  input  logic             x2,
  input  logic             x3,
  output logic [N_REQ-1:0] gnt,
  output logic             c0,
  output logic             c1,
  output logic             m,
  output logic             m_valid
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t           state;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] last_owner;
  logic [3:0]       hold_cnt;
  logic             mux_m;
  logic [SEL_W-1:0] arb_last;
  logic             release_now;
  arb_t             arb;

  // Rotate so the slot after `last` sits at bit 0, take the lowest set bit,
  // then rotate the index back into requester numbering.
  function automatic arb_t arbitrate(input logic [N_REQ-1:0] r,
                                     input logic [SEL_W-1:0] last);
    logic [SEL_W-1:0]   base;
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    arb_t               res;
    base = last + 1'b1;
    dbl  = {r, r} >> base;
    rot  = dbl[N_REQ-1:0];
    res  = '{found: 1'b0, idx: '0};
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        res.found = 1'b1;
        res.idx   = SEL_W'(i) + base;
      end
    end
    return res;
  endfunction

  mux u_mux (
    .x0 (x0),
    .x1 (x1),
    .x2 (x2),
    .x3 (x3),
    .c0 (sel[0]),
    .c1 (sel[1]),
    .m  (mux_m)
  );

  // While granted, the registered select is the owner; a dropped owner has
  // req[owner]==0 and so is naturally excluded from re-arbitration.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    arb_last    = last_owner;
    release_now = 1'b0;
    if (state == GRANT) begin
      arb_last    = sel;
      release_now = !req[sel] || (hold_cnt == HOLD_LAST);
    end
    arb = arbitrate(req, arb_last);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= '0;
      sel        <= '0;
      last_owner <= 2'd3;
      hold_cnt   <= '0;
      m          <= 1'b0;
      m_valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          m_valid <= 1'b0;
          if (arb.found) begin
            state    <= GRANT;
            gnt      <= onehot(arb.idx);
            sel      <= arb.idx;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          m       <= mux_m;
          m_valid <= 1'b1;
          if (release_now) begin
            last_owner <= sel;
            if (arb.found) begin
              gnt      <= onehot(arb.idx);
              sel      <= arb.idx;
              hold_cnt <= '0;
            end else begin
              gnt   <= '0;
              state <= IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign c0 = sel[0];
  assign c1 = sel[1];

endmodule
